detector_jogada: RTL and testbench

//  Front-end stage for the button inputs of the memory game. Synchronises and

---
 rtl/jogo_pkg.sv | 18 +
 rtl/sincronizador_2ff.sv | 31 +++
 rtl/detector_jogada.sv | 115 +++++++++++
 tb/tb_detector_jogada.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared constants for the memory-game front end: default sizes and the
// button-detector FSM encoding.
package jogo_pkg;

  localparam int N_BOTOES_DEF = 4;
  localparam int DEBOUNCE_DEF = 10;

  localparam logic [1:0] ESPERA       = 2'b00;
  localparam logic [1:0] FILTRA_PRESS = 2'b01;
  localparam logic [1:0] PRESSIONADO  = 2'b10;
  localparam logic [1:0] FILTRA_SOLTA = 2'b11;

  // True when exactly one bit is set (callers zero-extend narrower buses).
  function automatic logic eh_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser, one independent chain per bit, for bringing the raw
// asynchronous button levels into the clock domain.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/detector_jogada.sv
// Button front end: synchronise, debounce, then validate each physical press
// as one-hot and emit a registered play plus a single-cycle pulse.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                zera,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] jogada,
  output logic                tem_jogada,
  output logic                jogada_invalida,
  output logic [1:0]          db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BOTOES-1:0] s;

  logic [1:0]          estado_reg, estado_next;
  logic [N_BOTOES-1:0] cand_reg, cand_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [N_BOTOES-1:0] jogada_reg, jogada_next;
  logic                tem_reg, tem_next;
  logic                inv_reg, inv_next;

  sincronizador_2ff #(.WIDTH(N_BOTOES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s)
  );

  always_comb begin
    estado_next = estado_reg;
    cand_next   = cand_reg;
    cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
    jogada_next = zera ? '0 : jogada_reg;
    tem_next    = 1'b0;
    inv_next    = 1'b0;

    case (estado_reg)
      ESPERA: begin
        cnt_next = '0;
        if (s != '0) begin
          estado_next = FILTRA_PRESS;
          cand_next   = s;
          cnt_next    = CW'(1);
        end
      end
      FILTRA_PRESS: begin
        if (s == '0) begin
          estado_next = ESPERA;
          cnt_next    = '0;
        end else if (s != cand_reg) begin
          cand_next = s;
          cnt_next  = CW'(1);
        end else if (cnt_reg >= CNT_LAST) begin
          // A capture overrides a coincident zera so no play is ever lost.
          estado_next = PRESSIONADO;
          cnt_next    = '0;
          if (eh_one_hot(32'(cand_reg))) begin
            jogada_next = cand_reg;
            tem_next    = 1'b1;
          end else begin
            inv_next = 1'b1;
          end
        end
      end
      PRESSIONADO: begin
        cnt_next = '0;
        if (s == '0) estado_next = FILTRA_SOLTA;
      end
      default: begin
        if (s != '0) begin
          estado_next = PRESSIONADO;
          cnt_next    = '0;
        end else if (cnt_reg >= CNT_LAST) begin
          estado_next = ESPERA;
          cnt_next    = '0;
        end
      end
    endcase
  end

  // Reset lands in FILTRA_SOLTA so a button held through reset must be released first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg <= FILTRA_SOLTA;
      cand_reg   <= '0;
      cnt_reg    <= '0;
      jogada_reg <= '0;
      tem_reg    <= 1'b0;
      inv_reg    <= 1'b0;
    end else begin
      estado_reg <= estado_next;
      cand_reg   <= cand_next;
      cnt_reg    <= cnt_next;
      jogada_reg <= jogada_next;
      tem_reg    <= tem_next;
      inv_reg    <= inv_next;
    end
  end

  assign jogada          = jogada_reg;
  assign tem_jogada      = tem_reg;
  assign jogada_invalida = inv_reg;
  assign db_estado       = estado_reg;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada: expected pulses are queued when a press
// is driven and checked by a monitor when the DUT pulses.
`timescale 1us/1ns
module tb_detector_jogada;

  localparam int N   = 4;
  localparam int D   = 10;
  localparam int LAT = D + 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         zera  = 1'b0;
  logic [N-1:0] botoes = '0;
  logic [N-1:0] jogada;
  logic         tem_jogada;
  logic         jogada_invalida;
  logic [1:0]   db_estado;

  detector_jogada #(.N_BOTOES(N), .DEBOUNCE_CYCLES(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .zera            (zera),
    .botoes          (botoes),
    .jogada          (jogada),
    .tem_jogada      (tem_jogada),
    .jogada_invalida (jogada_invalida),
    .db_estado       (db_estado)
  );

  always #500 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit           inv;
    logic [N-1:0] jog;
    int           cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input bit inv, input logic [N-1:0] j);
    ev_t e;
    e.inv = inv;
    e.jog = j;
    e.cyc = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset && (tem_jogada || jogada_invalida)) begin
      $display("[TB] cyc=%0d pulse tem=%b inv=%b jogada=%b", cyc, tem_jogada, jogada_invalida, jogada);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, tem_jogada, jogada_invalida}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_kind", {31'd0, jogada_invalida}, {31'd0, e.inv});
        chk("pulse_exclusive", {31'd0, tem_jogada & jogada_invalida}, 32'd0);
        chk("pulse_jogada", {28'd0, jogada}, {28'd0, e.jog});
      end
    end
  end

  initial begin
    // 1. reset state and quiet-release timing
    step(2);
    chk("rst_jogada", {28'd0, jogada}, 32'd0);
    chk("rst_tem", {31'd0, tem_jogada}, 32'd0);
    chk("rst_inv", {31'd0, jogada_invalida}, 32'd0);
    chk("rst_estado", {30'd0, db_estado}, 32'd3);
    reset = 1'b1;
    step(9);
    chk("solta_9", {30'd0, db_estado}, 32'd3);
    step(1);
    chk("espera_10", {30'd0, db_estado}, 32'd0);

    // 2. clean single press
    botoes = 4'b0010;
    push_exp(1'b0, 4'b0010);
    step(20);
    botoes = 4'b0000;
    step(80);
    chk("t2_jogada", {28'd0, jogada}, 32'h2);
    chk("t2_estado", {30'd0, db_estado}, 32'd0);

    // 3. bouncing shorter than the debounce window
    for (int i = 0; i < 5; i++) begin
      botoes = 4'b0001;
      step(3);
      botoes = 4'b0000;
      step(3);
    end
    step(15);
    chk("t3_jogada", {28'd0, jogada}, 32'h2);

    // 4. multi-button press
    botoes = 4'b0101;
    push_exp(1'b1, 4'b0010);
    step(20);
    chk("t4_estado", {30'd0, db_estado}, 32'd2);
    chk("t4_jogada", {28'd0, jogada}, 32'h2);
    botoes = 4'b0000;
    step(30);

    // candidate change mid-filter restarts the window
    botoes = 4'b0010;
    step(5);
    botoes = 4'b0001;
    push_exp(1'b0, 4'b0001);
    step(20);
    botoes = 4'b0000;
    step(30);
    chk("restart_jogada", {28'd0, jogada}, 32'h1);

    // 5. reset in the middle of a hold
    botoes = 4'b0100;
    step(5);
    reset = 1'b0;
    step(2);
    chk("t5_rst_jogada", {28'd0, jogada}, 32'd0);
    chk("t5_rst_estado", {30'd0, db_estado}, 32'd3);
    reset = 1'b1;
    step(20);
    chk("t5_held_estado", {30'd0, db_estado}, 32'd2);
    chk("t5_held_jogada", {28'd0, jogada}, 32'd0);
    botoes = 4'b0000;
    step(30);
    chk("t5_release", {30'd0, db_estado}, 32'd0);
    botoes = 4'b0100;
    push_exp(1'b0, 4'b0100);
    step(20);
    botoes = 4'b0000;
    step(30);
    chk("t5_jogada", {28'd0, jogada}, 32'h4);

    // 6. zera coinciding with capture, then zera alone
    botoes = 4'b1000;
    push_exp(1'b0, 4'b1000);
    step(LAT - 1);
    zera = 1'b1;
    step(1);
    zera = 1'b0;
    chk("t6_capture_wins", {28'd0, jogada}, 32'h8);
    step(5);
    zera = 1'b1;
    step(1);
    zera = 1'b0;
    chk("t6_zera", {28'd0, jogada}, 32'd0);
    chk("t6_estado", {30'd0, db_estado}, 32'd2);
    botoes = 4'b0000;
    step(30);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
